bus_master_port: RTL
====================

Name: bus_master_port

Overview:
- Serial bus master interface sitting directly downstream of the controller.
- Accepts one read or write command per transaction via enable, read_en, addr_in and data_in.
- Requests the bus from the arbiter, serialises mode, address and write data onto the bus, and deserialises read data from the slave.
- Returns read data with a one-cycle done pulse, or an error pulse on timeout or lost grant.

Parameters:
ADDR_WIDTH, 14, address width; [13:12] slave id, [11:0] word address
DATA_WIDTH, 8, data word width
TIMEOUT, 255, max cycles waiting in WAIT_ACK or RDATA before abort

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  command strobe from controller; sampled only in IDLE
read_en  input  1  1 = read, 0 = write; latched with enable
addr_in  input  ADDR_WIDTH  target address; latched with enable
data_in  input  DATA_WIDTH  write data; latched with enable
bus_req  output  1  bus request to arbiter
bus_grant  input  1  grant from arbiter
m_dout  output  1  serial line to slave
m_dout_valid  output  1  qualifies m_dout
m_din  input  1  serial line from slave
m_din_valid  input  1  qualifies m_din
slave_ack  input  1  slave address-accept strobe
data_out  output  DATA_WIDTH  last read word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse on abort

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, including data_out.
  - Bit counter, timeout counter and latched command cleared.
- IDLE:
  - enable=1 latches read_en, addr_in and data_in, then moves to REQ.
  - enable is ignored in all other states; no queuing.
- REQ:
  - bus_req=1.
  - Waits indefinitely for bus_grant=1, then moves to ADDR.
  - bus_req stays high from REQ until DONE/ABORT.
- ADDR:
  - m_dout_valid=1 for exactly 1+ADDR_WIDTH consecutive cycles.
  - First bit is the mode bit (latched read_en), followed by address bits LSB first.
  - Then moves to WAIT_ACK.
- WAIT_ACK:
  - m_dout_valid=0.
  - slave_ack=1 moves to WDATA (write) or RDATA (read).
  - TIMEOUT cycles without ack moves to ABORT.
  - Timeout counter resets on entry.
- WDATA:
  - m_dout_valid=1 for DATA_WIDTH consecutive cycles, data LSB first.
  - Then moves to DONE.
- RDATA:
  - Shifts m_din in on each cycle with m_din_valid=1, LSB first.
  - Gaps in m_din_valid are allowed.
  - After DATA_WIDTH valid bits, data_out updates on the same edge the last bit is captured, then moves to DONE.
  - The timeout counter restarts on every valid bit; TIMEOUT idle cycles moves to ABORT, and data_out is left unchanged.
- DONE: done=1 and bus_req=0 for one cycle, then IDLE.
- ABORT: error=1 and bus_req=0 for one cycle, then IDLE. done is not asserted.
- Lost grant: bus_grant=0 in ADDR, WAIT_ACK, WDATA or RDATA moves to ABORT on the next edge. Any partial read is discarded.
- Simultaneous events: slave_ack together with a timeout expiry in the same cycle counts as ack (ack wins).
- Write latency from enable (cycle 0), grant held, ack in the first WAIT_ACK cycle:
  - REQ at 1
  - ADDR at 2..16
  - WAIT_ACK at 17
  - WDATA at 18..25
  - done at 26
- Reset asserted mid-transaction: immediate IDLE, outputs cleared, no done/error pulse.

Test Plan:
- Write: enable with read_en=0, addr_in=14'h1ABC, data_in=8'hA5; grant held; ack at first WAIT_ACK cycle -> m_dout stream is 0 then 0x1ABC LSB first over cycles 2..16, then 1,0,1,0,0,1,0,1 over 18..25; done pulse at cycle 26; bus_req low at 26.
- Read: read_en=1, addr_in=14'h2005; slave returns 8'h3C with one idle cycle between bits 3 and 4 -> first serial bit 1; data_out=8'h3C; done once; error never asserted.
- Ack timeout: slave_ack never asserted -> error pulse exactly TIMEOUT cycles after WAIT_ACK entry; bus_req drops with it; done=0; back in IDLE.
- Grant delay and lost grant: grant arrives 5 cycles after REQ, ADDR starts the next cycle; separately, grant dropped in WDATA bit 3 -> error pulse, no further m_dout_valid.
- enable pulsed while busy with addr_in=14'h0001 -> ignored; the original transaction completes unchanged.
- Reset during RDATA after 4 bits -> all outputs 0 immediately, data_out=0; a subsequent write completes normally.

Source files
------------

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - serial bus master port: arbitration, address/data serialiser, read deserialiser
//
// Purpose: takes one read or write command from the controller, requests the
// bus, shifts out {mode, address} and write data LSB first, shifts in read
// data LSB first, and finishes with a one-cycle done or error pulse.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   enable, read_en       command strobe and direction (1 = read), IDLE only
//   addr_in, data_in      command address and write data, latched with enable
//   bus_req, bus_grant    arbiter handshake
//   m_dout, m_dout_valid  serial output to slave
//   m_din, m_din_valid    serial input from slave
//   slave_ack             slave address-accept strobe
//   data_out              last successfully read word
//   busy, done, error     status: not-IDLE, success pulse, abort pulse
module bus_master_port #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic                  m_dout,
  output logic                  m_dout_valid,
  input  logic                  m_din,
  input  logic                  m_din_valid,
  input  logic                  slave_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // One shift register serves both the {address, mode} frame and write data.
  localparam int SH_W   = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int BCNT_W = $clog2(SH_W);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [BCNT_W-1:0] ADDR_LAST = BCNT_W'(ADDR_WIDTH);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_WIDTH - 1);
  localparam logic [TCNT_W-1:0] TO_LAST   = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WAIT_ACK, S_WDATA, S_RDATA, S_DONE, S_ABORT
  } state_t;

  state_t                  state;
  logic                    cmd_read;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [SH_W-1:0]         shreg;
  logic [DATA_WIDTH-1:0]   rsh;
  logic [BCNT_W-1:0]       bit_cnt;
  logic [TCNT_W-1:0]       tcnt;

  // m_dout is the LSB of a register, so it is glitch-free like the other outputs.
  assign m_dout = shreg[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cmd_read     <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      shreg        <= '0;
      rsh          <= '0;
      bit_cnt      <= '0;
      tcnt         <= '0;
      bus_req      <= 1'b0;
      m_dout_valid <= 1'b0;
      data_out     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            cmd_read <= read_en;
            cmd_addr <= addr_in;
            cmd_data <= data_in;
            state    <= S_REQ;
            bus_req  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_grant) begin
            state        <= S_ADDR;
            shreg        <= SH_W'({cmd_addr, cmd_read});
            bit_cnt      <= '0;
            m_dout_valid <= 1'b1;
          end
        end
        default: begin
          // Losing the grant anywhere on the bus beats every other event.
          if ((state == S_ADDR || state == S_WAIT_ACK || state == S_WDATA ||
               state == S_RDATA) && !bus_grant) begin
            state        <= S_ABORT;
            bus_req      <= 1'b0;
            m_dout_valid <= 1'b0;
            error        <= 1'b1;
          end else begin
            case (state)
              S_ADDR: begin
                if (bit_cnt == ADDR_LAST) begin
                  state        <= S_WAIT_ACK;
                  m_dout_valid <= 1'b0;
                  tcnt         <= '0;
                end else begin
                  shreg   <= {1'b0, shreg[SH_W-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              S_WAIT_ACK: begin
                // Ack is checked before the timeout so a coincident ack wins.
                if (slave_ack) begin
                  bit_cnt <= '0;
                  tcnt    <= '0;
                  if (cmd_read) begin
                    state <= S_RDATA;
                    rsh   <= '0;
                  end else begin
                    state        <= S_WDATA;
                    shreg        <= SH_W'(cmd_data);
                    m_dout_valid <= 1'b1;
                  end
                end else if (tcnt == TO_LAST) begin
                  state   <= S_ABORT;
                  bus_req <= 1'b0;
                  error   <= 1'b1;
                end else begin
                  tcnt <= tcnt + 1'b1;
                end
              end
              S_WDATA: begin
                if (bit_cnt == DATA_LAST) begin
                  state        <= S_DONE;
                  m_dout_valid <= 1'b0;
                  bus_req      <= 1'b0;
                  done         <= 1'b1;
                end else begin
                  shreg   <= {1'b0, shreg[SH_W-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              S_RDATA: begin
                if (m_din_valid) begin
                  rsh  <= {m_din, rsh[DATA_WIDTH-1:1]};
                  tcnt <= '0;
                  if (bit_cnt == DATA_LAST) begin
                    data_out <= {m_din, rsh[DATA_WIDTH-1:1]};
                    state    <= S_DONE;
                    bus_req  <= 1'b0;
                    done     <= 1'b1;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end else if (tcnt == TO_LAST) begin
                  state   <= S_ABORT;
                  bus_req <= 1'b0;
                  error   <= 1'b1;
                end else begin
                  tcnt <= tcnt + 1'b1;
                end
              end
              default: begin
                // S_DONE / S_ABORT: pulse already registered on entry.
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
